// File: rtl/proc_datapath_core_if.sv
// Signal bundle between the sequencer and the processor datapath core:
// ALU operands/results, status flags, and both memory read/write ports.
interface proc_datapath_core_if #(
    parameter int AW = 10,
    parameter int DW = 16,
    parameter int IW = 32
);
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_sel;
    logic [DW-1:0] alu_out_hi;
    logic [DW-1:0] alu_out_lo;
    logic          c_flag;
    logic          z_flag;
    logic          v_flag;

    logic          im_wr_en;
    logic [AW-1:0] im_wr_addr;
    logic [IW-1:0] im_wr_data;
    logic [AW-1:0] im_rd_addr;
    logic [IW-1:0] im_rd_data;

    logic          dm_wr_en;
    logic [AW-1:0] dm_wr_addr;
    logic [DW-1:0] dm_wr_data;
    logic [AW-1:0] dm_rd_addr;
    logic [DW-1:0] dm_rd_data;

    modport master (
        output alu_a, alu_b, alu_sel,
        input  alu_out_hi, alu_out_lo, c_flag, z_flag, v_flag,
        output im_wr_en, im_wr_addr, im_wr_data, im_rd_addr,
        input  im_rd_data,
        output dm_wr_en, dm_wr_addr, dm_wr_data, dm_rd_addr,
        input  dm_rd_data
    );

    modport slave (
        input  alu_a, alu_b, alu_sel,
        output alu_out_hi, alu_out_lo, c_flag, z_flag, v_flag,
        input  im_wr_en, im_wr_addr, im_wr_data, im_rd_addr,
        output im_rd_data,
        input  dm_wr_en, dm_wr_addr, dm_wr_data, dm_rd_addr,
        output dm_rd_data
    );
endinterface

// File: rtl/proc_datapath_core.sv
// Processor datapath core: combinational ALU with a registered C/Z/V flag
// register, plus an instruction/stack memory and a data memory (async reads).
module proc_datapath_core #(
    parameter int AW     = 10,
    parameter int DW     = 16,
    parameter int IW     = 32,
    parameter int IM_DEP = 1024,
    parameter int DM_DEP = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    proc_datapath_core_if.slave   bus
);

    function automatic logic add_ovf(input logic signed [DW-1:0] x,
                                     input logic signed [DW-1:0] y,
                                     input logic signed [DW-1:0] r);
        return (x[DW-1] == y[DW-1]) && (r[DW-1] != x[DW-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DW-1:0] x,
                                     input logic signed [DW-1:0] y,
                                     input logic signed [DW-1:0] r);
        return (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
    endfunction

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0]        a;
    logic [DW-1:0]        b;
    logic signed [DW-1:0] a_s;
    logic [3:0]           sh;
    logic [DW:0]          wide;
    logic [2*DW-1:0]      prod;
    logic [DW-1:0]        res_lo;
    logic [DW-1:0]        res_hi;
    logic                 c_nxt;
    logic                 v_nxt;
    logic                 c_q;
    logic                 z_q;
    logic                 v_q;

    assign a   = bus.alu_a;
    assign b   = bus.alu_b;
    assign a_s = $signed(bus.alu_a);
    assign sh  = bus.alu_b[3:0];

    // Shifts run through a DW+1 wide word so the last bit shifted out lands in the extra bit
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        c_nxt  = 1'b0;
        v_nxt  = 1'b0;
        wide   = '0;
        prod   = '0;
        case (bus.alu_sel)
            4'h0: begin
                wide   = {1'b0, a} + {1'b0, b};
                res_lo = wide[DW-1:0];
                c_nxt  = wide[DW];
                v_nxt  = add_ovf(a, b, wide[DW-1:0]);
            end
            4'h1: begin
                wide   = {1'b0, a} - {1'b0, b};
                res_lo = wide[DW-1:0];
                c_nxt  = wide[DW];
                v_nxt  = sub_ovf(a, b, wide[DW-1:0]);
            end
            4'h2: begin
                prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                res_lo = prod[DW-1:0];
                res_hi = prod[2*DW-1:DW];
            end
            4'h3: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                    v_nxt  = 1'b1;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            4'h4: res_lo = a & b;
            4'h5: res_lo = a | b;
            4'h6: res_lo = a ^ b;
            4'h7: res_lo = ~a;
            4'h8: begin
                wide   = {1'b0, a} << sh;
                res_lo = wide[DW-1:0];
                c_nxt  = wide[DW];
            end
            4'h9: begin
                wide   = {a, 1'b0} >> sh;
                res_lo = wide[DW:1];
                c_nxt  = wide[0];
            end
            4'hA: res_lo = a_s >>> sh;
            4'hB: begin
                wide   = {1'b0, a} + {1'b0, ONE};
                res_lo = wide[DW-1:0];
                c_nxt  = wide[DW];
                v_nxt  = add_ovf(a, ONE, wide[DW-1:0]);
            end
            4'hC: begin
                wide   = {1'b0, a} - {1'b0, ONE};
                res_lo = wide[DW-1:0];
                c_nxt  = wide[DW];
                v_nxt  = sub_ovf(a, ONE, wide[DW-1:0]);
            end
            4'hD: res_lo = a;
            4'hE: res_lo = b;
            default: res_lo = '0;
        endcase
    end

    assign bus.alu_out_lo = res_lo;
    assign bus.alu_out_hi = res_hi;

    // Flag register: loads every edge, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            c_q <= c_nxt;
            z_q <= (res_lo == '0);
            v_q <= v_nxt;
        end
    end

    assign bus.c_flag = c_q;
    assign bus.z_flag = z_q;
    assign bus.v_flag = v_q;

    // Memories are never cleared; reset only blocks writes while it is asserted
    logic [IW-1:0] im_mem [IM_DEP];
    logic [DW-1:0] dm_mem [DM_DEP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && bus.im_wr_en)
            im_mem[bus.im_wr_addr] <= bus.im_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && bus.dm_wr_en)
            dm_mem[bus.dm_wr_addr] <= bus.dm_wr_data;
    end

    assign bus.im_rd_data = im_mem[bus.im_rd_addr];
    assign bus.dm_rd_data = dm_mem[bus.dm_rd_addr];

endmodule

// File: tb/tb_proc_datapath_core.sv
// Scoreboard bench for proc_datapath_core: stimulus pushes expected results,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_proc_datapath_core;

    logic clk;
    logic rst_n;

    proc_datapath_core_if #(.AW(10), .DW(16), .IW(32)) bus ();

    proc_datapath_core #(
        .AW(10), .DW(16), .IW(32), .IM_DEP(1024), .DM_DEP(1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        c;
        logic        z;
        logic        v;
        bit          im_chk;
        logic [31:0] im;
        bit          dm_chk;
        logic [15:0] dm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rec_id = 0;

    logic [31:0] im_m [1024];
    bit          im_v [1024];
    logic [15:0] dm_m [1024];
    bit          dm_v [1024];

    bit flag_c, flag_z, flag_v;

    // Reference ALU: plain integer arithmetic on the opcode definitions
    function automatic void ref_alu(input logic [3:0] sel, input logic [15:0] a16, input logic [15:0] b16,
                                    output logic [15:0] lo, output logic [15:0] hi,
                                    output bit c, output bit v);
        longint unsigned a = a16;
        longint unsigned b = b16;
        longint sa = longint'($signed(a16));
        longint sb = longint'($signed(b16));
        longint sr;
        longint unsigned p;
        int n = int'(b16 % 16);
        lo = 16'h0; hi = 16'h0; c = 0; v = 0;
        case (sel)
            4'h0: begin lo = 16'(a + b); c = (a + b) > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            4'h1: begin lo = 16'(a - b); c = a < b; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            4'h2: begin p = a * b; lo = 16'(p); hi = 16'(p >> 16); end
            4'h3: begin
                if (b == 0) begin lo = 16'hFFFF; hi = a16; v = 1; end
                else begin lo = 16'(a / b); hi = 16'(a % b); end
            end
            4'h4: lo = a16 & b16;
            4'h5: lo = a16 | b16;
            4'h6: lo = a16 ^ b16;
            4'h7: lo = 16'(65535 - a);
            4'h8: begin p = a * (64'd1 << n); lo = 16'(p); c = (n > 0) && (((p >> 16) & 1) == 1); end
            4'h9: begin lo = 16'(a >> n); c = (n > 0) && (((a >> (n - 1)) & 1) == 1); end
            4'hA: lo = 16'(sa >>> n);
            4'hB: begin lo = 16'(a + 1); c = (a == 65535); v = (sa == 32767); end
            4'hC: begin lo = 16'(a - 1); c = (a == 0); v = (sa == -32768); end
            4'hD: lo = a16;
            4'hE: lo = b16;
            default: lo = 16'h0;
        endcase
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s (rec %0d): got %h, expected %h", name, id, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alu_out_lo", e.id, 32'(bus.alu_out_lo), 32'(e.lo));
                chk("alu_out_hi", e.id, 32'(bus.alu_out_hi), 32'(e.hi));
                chk("flags_czv", e.id, {29'd0, bus.c_flag, bus.z_flag, bus.v_flag}, {29'd0, e.c, e.z, e.v});
                if (e.im_chk) chk("im_rd_data", e.id, bus.im_rd_data, e.im);
                if (e.dm_chk) chk("dm_rd_data", e.id, 32'(bus.dm_rd_data), 32'(e.dm));
            end
        end
    end

    // Expected outputs for the inputs currently on the bus; flags are what the register holds now
    task automatic push_rec(input bit in_reset);
        exp_t e;
        bit c, v;
        e.id = rec_id++;
        ref_alu(bus.alu_sel, bus.alu_a, bus.alu_b, e.lo, e.hi, c, v);
        e.c = in_reset ? 1'b0 : flag_c;
        e.z = in_reset ? 1'b0 : flag_z;
        e.v = in_reset ? 1'b0 : flag_v;
        e.im_chk = im_v[bus.im_rd_addr];
        e.im     = im_m[bus.im_rd_addr];
        e.dm_chk = dm_v[bus.dm_rd_addr];
        e.dm     = dm_m[bus.dm_rd_addr];
        exp_q.push_back(e);
    endtask

    task automatic load_flags_from_inputs();
        logic [15:0] lo, hi;
        bit c, v;
        ref_alu(bus.alu_sel, bus.alu_a, bus.alu_b, lo, hi, c, v);
        flag_c = c; flag_z = (lo == 16'h0); flag_v = v;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                         input bit imw, input logic [9:0] ima, input logic [31:0] imd, input logic [9:0] imr,
                         input bit dmw, input logic [9:0] dma, input logic [15:0] dmd, input logic [9:0] dmr);
        @(posedge clk);
        // Flags latched at this edge came from the previous inputs
        load_flags_from_inputs();
        #1;
        bus.alu_sel = sel; bus.alu_a = a; bus.alu_b = b;
        bus.im_wr_en = imw; bus.im_wr_addr = ima; bus.im_wr_data = imd; bus.im_rd_addr = imr;
        bus.dm_wr_en = dmw; bus.dm_wr_addr = dma; bus.dm_wr_data = dmd; bus.dm_rd_addr = dmr;
        push_rec(1'b0);
        if (imw) begin im_m[ima] = imd; im_v[ima] = 1; end
        if (dmw) begin dm_m[dma] = dmd; dm_v[dma] = 1; end
    endtask

    task automatic alu(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        drive(sel, a, b, 0, 10'd0, 32'd0, bus.im_rd_addr, 0, 10'd0, 16'd0, bus.dm_rd_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  sel;
        logic [15:0] ra, rb;
        for (int i = 0; i < 1024; i++) begin im_v[i] = 0; dm_v[i] = 0; end
        flag_c = 0; flag_z = 0; flag_v = 0;
        rst_n = 1'b0;
        bus.alu_sel = 4'hF; bus.alu_a = 16'h0; bus.alu_b = 16'h0;
        bus.im_wr_en = 0; bus.im_wr_addr = '0; bus.im_wr_data = '0; bus.im_rd_addr = '0;
        bus.dm_wr_en = 0; bus.dm_wr_addr = '0; bus.dm_wr_data = '0; bus.dm_rd_addr = '0;

        // Reset state: flags held at 0 across clock edges
        repeat (2) @(posedge clk);
        #1 push_rec(1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;

        alu(4'h0, 16'h7FFF, 16'h0001);
        alu(4'h1, 16'd5, 16'd5);
        alu(4'h1, 16'd3, 16'd5);
        alu(4'h2, 16'h1234, 16'h0100);
        alu(4'h3, 16'd100, 16'd7);
        alu(4'h3, 16'hBEEF, 16'd0);
        alu(4'hB, 16'hFFFF, 16'd0);
        alu(4'hC, 16'h8000, 16'd0);
        alu(4'h8, 16'hC001, 16'd2);
        alu(4'h9, 16'h0003, 16'd2);
        alu(4'hA, 16'h8004, 16'd2);
        alu(4'hF, 16'h1111, 16'h2222);

        // Stack region of IM: neighbour word must survive the write
        drive(4'hD, 16'h1, 16'h0, 1, 10'd1004, 32'hAAAA_5555, 10'd1004, 0, 10'd0, 16'd0, 10'd0);
        drive(4'hD, 16'h2, 16'h0, 1, 10'd1005, 32'h1234_5678, 10'd1005, 0, 10'd0, 16'd0, 10'd0);
        drive(4'hD, 16'h3, 16'h0, 0, 10'd1005, 32'hFFFF_FFFF, 10'd1005, 0, 10'd0, 16'd0, 10'd0);
        drive(4'hD, 16'h4, 16'h0, 0, 10'd0, 32'd0, 10'd1004, 0, 10'd0, 16'd0, 10'd0);

        // DM read-during-write: old value this cycle, new one after
        drive(4'hD, 16'h5, 16'h0, 0, 10'd0, 32'd0, 10'd0, 1, 10'd10, 16'd1, 10'd10);
        drive(4'hD, 16'h6, 16'h0, 0, 10'd0, 32'd0, 10'd0, 1, 10'd10, 16'd42, 10'd10);
        drive(4'hD, 16'h7, 16'h0, 0, 10'd0, 32'd0, 10'd0, 0, 10'd10, 16'd99, 10'd10);
        drive(4'hD, 16'h8, 16'h0, 0, 10'd0, 32'd0, 10'd0, 0, 10'd10, 16'd99, 10'd10);

        // Async reset mid-cycle with z set
        alu(4'h1, 16'd9, 16'd9);
        alu(4'h1, 16'd9, 16'd9);
        @(posedge clk);
        load_flags_from_inputs();
        #2 rst_n = 1'b0;
        #1 push_rec(1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        alu(4'h1, 16'd9, 16'd9);
        alu(4'h4, 16'hF0F0, 16'h3C3C);

        for (int i = 0; i < 300; i++) begin
            sel = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                2: ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: rb = 16'h0;
                1: rb = 16'h1;
                default: rb = 16'($urandom);
            endcase
            drive(sel, ra, rb,
                  $urandom_range(0, 1) == 1, 10'($urandom_range(1000, 1007)), $urandom, 10'($urandom_range(1000, 1007)),
                  $urandom_range(0, 1) == 1, 10'($urandom_range(8, 15)), 16'($urandom), 10'($urandom_range(8, 15)));
        end
        alu(4'hF, 16'h0, 16'h0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
